// File: rtl/byte_lane_packer.sv
// Byte-serial valid/ready stream packed into a LANES-wide word of byte lanes with keep/last.
// Accumulator plus output register: input keeps streaming while one finished word waits downstream.

module byte_lane_packer_lane #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] wdata,
   output logic             wkeep
);
   logic [WIDTH-1:0] data;
   logic             keep;

   // clr wins over wr: a completing byte bypasses the lane straight into the output register
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         data <= '0;
         keep <= 1'b0;
      end else if (wr) begin
         data <= din;
         keep <= 1'b1;
      end
   end

   assign wdata = wr ? din : data;
   assign wkeep = keep | wr;
endmodule

module byte_lane_packer #(
   parameter int WIDTH = 8,
   parameter int LANES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data [LANES-1:0],
   output logic [LANES-1:0] out_keep,
   output logic             out_last
);
   localparam int CW = $clog2(LANES);

   typedef enum logic {FILL, HOLD} state_t;
   state_t state, state_nx;

   logic [CW-1:0]    cnt;
   logic             acc_last;
   logic             in_fire, slot_free, word_done, load, w_last;
   logic [LANES-1:0] lane_wr, w_keep;
   logic [WIDTH-1:0] w_data [LANES-1:0];

   assign in_fire   = in_valid && in_ready;
   assign slot_free = !out_valid || out_ready;
   assign word_done = in_fire && ((cnt == CW'(LANES-1)) || in_last);
   assign load      = (state == FILL) ? (word_done && slot_free) : slot_free;
   // in FILL the word closing this cycle takes its last flag straight from the input
   assign w_last    = (state == FILL) ? in_last : acc_last;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_wr[gi] = in_fire && (cnt == CW'(gi));
         byte_lane_packer_lane #(.WIDTH(WIDTH)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .wr    (lane_wr[gi]),
            .clr   (load),
            .din   (in_data),
            .wdata (w_data[gi]),
            .wkeep (w_keep[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         FILL: if (word_done && !slot_free) state_nx = HOLD;
         HOLD: if (slot_free)               state_nx = FILL;
         default:                           state_nx = FILL;
      endcase
   end

   always_comb begin
      in_ready = !rst && (state == FILL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         acc_last <= 1'b0;
      end else begin
         if (word_done)    cnt <= '0;
         else if (in_fire) cnt <= cnt + CW'(1);
         if (word_done && !slot_free) acc_last <= in_last;
         else if (load)               acc_last <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_keep  <= '0;
         out_last  <= 1'b0;
         for (int i = 0; i < LANES; i++) out_data[i] <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_keep  <= w_keep;
         out_last  <= w_last;
         for (int i = 0; i < LANES; i++) out_data[i] <= w_keep[i] ? w_data[i] : '0;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_byte_lane_packer.sv
// Scoreboard bench for byte_lane_packer: byte-level model builds expected words, a negedge monitor checks them.

module tb_byte_lane_packer;
   localparam int W = 8;
   localparam int L = 4;

   typedef logic [L*W+L:0] word_t;  // {last, keep, lane L-1 .. lane 0}

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_data = '0;
   logic         in_last = 1'b0;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data [L-1:0];
   logic [L-1:0] out_keep;
   logic         out_last;

   bit   rand_en = 1'b0;
   logic dir_ready = 1'b0;
   logic rnd_ready = 1'b0;
   assign out_ready = rand_en ? rnd_ready : dir_ready;

   byte_lane_packer #(.WIDTH(W), .LANES(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_keep  (out_keep),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [W-1:0] cur[$];
   word_t        exp_q[$];
   word_t        log_q[$];
   bit           held = 1'b0;
   word_t        held_word;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic word_t dut_word();
      word_t w;
      w = '0;
      for (int i = 0; i < L; i++) w[i*W +: W] = out_data[i];
      w[L*W +: L] = out_keep;
      w[L*W+L]    = out_last;
      return w;
   endfunction

   always @(posedge clk) begin
      #1;
      rnd_ready = ($urandom_range(0, 2) != 0);
   end

   // Monitor + reference model: bytes accumulate in a list; a word closes at L bytes or on last.
   always @(negedge clk) begin
      if (rst) begin
         cur.delete();
         exp_q.delete();
         held = 1'b0;
      end else begin
         if (held) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_stable", 64'(dut_word()), 64'(held_word));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_word", 64'(dut_word()), 64'(0));
               if (dut_word() == '0) begin
                  fails++;
                  $display("FAIL unexpected_word: got zero word expected none");
               end
            end else begin
               word_t e;
               e = exp_q.pop_front();
               check("word", 64'(dut_word()), 64'(e));
            end
            log_q.push_back(dut_word());
         end
         held      = out_valid && !out_ready;
         held_word = dut_word();
         if (in_valid && in_ready) begin
            cur.push_back(in_data);
            if (cur.size() == L || in_last) begin
               word_t e;
               e = '0;
               for (int i = 0; i < cur.size(); i++) begin
                  e[i*W +: W] = cur[i];
                  e[L*W + i]  = 1'b1;
               end
               e[L*W+L] = in_last;
               exp_q.push_back(e);
               cur.delete();
            end
         end
      end
   end

   task automatic send_byte(input logic [W-1:0] d, input logic l, output int waits);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      waits    = 0;
      @(negedge clk);
      while (!in_ready && waits < 500) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: got no in_ready expected acceptance within 500 cycles");
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int w, tw, lb, k;

      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_word", 64'(dut_word()), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rel_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;

      // Back-to-back full words, no backpressure
      dir_ready = 1'b1;
      lb = log_q.size();
      tw = 0;
      for (int i = 0; i < 8; i++) begin
         send_byte(8'(8'h11 * (i + 1)), 1'b0, w);
         tw += w;
         if (i == 3) begin
            check("t1_lat1", 64'(out_valid), 64'(1));
            check("t1_word1", 64'(dut_word()), 64'({1'b0, 4'hf, 32'h44332211}));
         end
         if (i == 7) begin
            check("t1_lat2", 64'(out_valid), 64'(1));
            check("t1_word2", 64'(dut_word()), 64'({1'b0, 4'hf, 32'h88776655}));
         end
      end
      idle(2);
      check("t1_ready_never_dropped", 64'(tw), 64'(0));
      check("t1_word_count", 64'(log_q.size() - lb), 64'(2));

      // Early last on lane 2, then single-byte word
      send_byte(8'hA0, 1'b0, w);
      send_byte(8'hB0, 1'b0, w);
      send_byte(8'hC0, 1'b1, w);
      in_valid = 1'b0;
      check("t2_word", 64'(dut_word()), 64'({1'b1, 4'b0111, 32'h00C0B0A0}));
      idle(2);
      send_byte(8'h5A, 1'b1, w);
      in_valid = 1'b0;
      check("t3_word", 64'(dut_word()), 64'({1'b1, 4'b0001, 32'h0000005A}));
      idle(2);

      // Backpressure: word 1 held, word 2 parked in accumulator, input stalls
      dir_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send_byte(8'(8'h30 + i), 1'b0, w);
         if (i == 3) check("t4_word1", 64'(dut_word()), 64'({1'b0, 4'hf, 32'h33323130}));
      end
      check("t4_hold_ready", 64'(in_ready), 64'(0));
      check("t4_word1_held", 64'(dut_word()), 64'({1'b0, 4'hf, 32'h33323130}));
      in_valid = 1'b1;
      in_data  = 8'h99;
      in_last  = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("t4_no_accept", 64'(in_ready), 64'(0));
      end
      @(posedge clk);
      #1;
      dir_ready = 1'b1;
      @(posedge clk);
      #1;
      dir_ready = 1'b0;
      check("t4_word2_valid", 64'(out_valid), 64'(1));
      check("t4_word2", 64'(dut_word()), 64'({1'b0, 4'hf, 32'h37363534}));
      check("t4_ready_back", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("t4_hold_again", 64'(in_ready), 64'(0));
      dir_ready = 1'b1;
      idle(3);
      check("t4_drained", 64'(exp_q.size()), 64'(0));
      check("t4_last_word", 64'(log_q[log_q.size()-1]), 64'({1'b1, 4'b0001, 32'h00000099}));

      // Reset mid-word discards the partial word
      lb = log_q.size();
      send_byte(8'hE1, 1'b0, w);
      send_byte(8'hE2, 1'b0, w);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("t5_out_valid", 64'(out_valid), 64'(0));
      idle(2);
      check("t5_no_output", 64'(log_q.size() - lb), 64'(0));
      for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0, w);
      idle(2);
      check("t5_count", 64'(log_q.size() - lb), 64'(1));
      check("t5_word", 64'(log_q[log_q.size()-1]), 64'({1'b0, 4'hf, 32'h04030201}));

      // Random gaps, random last, random backpressure
      rand_en = 1'b1;
      lb = log_q.size();
      for (int n = 0; n < 1000; n++) begin
         k = $urandom_range(0, 3);
         if (k != 0) begin
            in_data = 8'($urandom);
            in_last = 1'($urandom);
            idle(k);
         end
         send_byte(8'($urandom), ($urandom_range(0, 7) == 0), w);
      end
      send_byte(8'hFE, 1'b1, w);
      in_valid = 1'b0;
      rand_en  = 1'b0;
      dir_ready = 1'b1;
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(posedge clk);
         k++;
      end
      #1;
      check("t6_drained", 64'(exp_q.size()), 64'(0));
      check("t6_some_words", 64'(log_q.size() - lb >= 250), 64'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/byte_lane_packer.md
# byte_lane_packer

Collects a byte-serial valid/ready stream into a word of `LANES` byte lanes. It presents the word as an unpacked lane array with a keep mask and a last flag. It sits directly upstream of the lane-array consumer (`logic [7:0] b [3:0]`) and produces exactly that port shape. A two-deep structure (accumulator plus output register) keeps the input streaming while a completed word waits downstream.

## Interface
- `WIDTH`, 8: bits per lane.
- `LANES`, 4: lanes per output word; must be ≥ 2.
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  input byte valid.
- `in_ready`  out  1  block accepts a byte this cycle.
- `in_data`  in  WIDTH  input byte.
- `in_last`  in  1  byte closes the current word early (end of packet).
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  WIDTH × [LANES] unpacked, `[LANES-1:0]`  lane 0 = first byte received.
- `out_keep`  out  LANES  bit i set = lane i holds a real byte.
- `out_last`  out  1  word ended by `in_last`.

## Operation
- An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- Accumulator: lane registers `acc[LANES]`, mask `acc_keep`, fill counter `cnt` (0..LANES-1), and a state machine with states FILL and HOLD.
- FILL:
  - `in_ready` = 1.
  - On an input transfer, write `acc[cnt] = in_data` and set `acc_keep[cnt]`.
  - If `cnt == LANES-1` or `in_last`, the word is complete. Otherwise `cnt` increments.
- Completing a word:
  - If the output slot is free this cycle (`!out_valid || out_ready`), the completed word, including the current byte, loads the output register at the same edge.
  - After the load: `cnt`=0, `acc_keep`=0, state stays FILL.
  - If the slot is not free, the word stays in `acc` and the state goes to HOLD.
- HOLD:
  - `in_ready` = 0.
  - When `!out_valid || out_ready`, the word moves to the output register, the accumulator clears, and the state returns to FILL.
- Output register contents:
  - Lanes whose keep bit is clear are driven to 0.
  - `out_last` = 1 iff the word was closed by `in_last`.
  - If `in_last` arrives on lane LANES-1, `out_keep` is all-ones and `out_last` = 1.
- Output register hold: while `out_valid && !out_ready`, `out_data`, `out_keep` and `out_last` hold stable.
- `out_valid` clears after an output transfer unless a new word loads at that same edge.
- No zero-length words: `in_last` is only meaningful with `in_valid`.

## Timing
- Reset values (registered outputs):
  - `out_valid`=0, `out_data` all lanes 0, `out_keep`=0, `out_last`=0.
  - State FILL, `cnt`=0, accumulator cleared.
- `in_ready` is combinational: `!rst && state==FILL`. It is 0 while `rst` is high and 1 in the first cycle after release.
- Latency: the completing byte accepted at edge N gives `out_valid`=1 in the cycle after edge N, provided the output slot is free.
- Simultaneous output transfer and word completion at the same edge: the new word replaces the old one, `out_valid` stays 1, and no bubble is inserted.
- HOLD exit: transfer at edge M gives `in_ready`=1 in the cycle after edge M. There is one dead input cycle per stall.
- Throughput: one byte per cycle sustained while `out_ready`=1.
- Reset mid-word or mid-HOLD: the partial word and the output register are discarded with no output.
- `in_data` and `in_last` are ignored when no input transfer occurs.

## Test plan
- Eight bytes 0x11..0x88, `in_valid`=1 continuously, `out_ready`=1 -> two words result:
  - {0x11,0x22,0x33,0x44} with keep 4'b1111, last 0.
  - {0x55,0x66,0x77,0x88} with keep 4'b1111, last 0.
  - Each word is valid exactly one cycle after its 4th byte, and `in_ready` never drops.
- Bytes 0xA0,0xB0,0xC0 with `in_last` on 0xC0 -> word {0xA0,0xB0,0xC0,0x00}, keep 4'b0111, last 1.
- Single byte 0x5A with `in_last` -> word {0x5A,0,0,0}, keep 4'b0001, last 1.
- `out_ready`=0, 8 bytes offered:
  - Word 1 is held stable and word 2 fills the accumulator.
  - `in_ready`=0 after byte 8 (HOLD), so byte 9 is not accepted.
  - Raise `out_ready` for one cycle: word 1 transfers, word 2 is valid the next cycle, and `in_ready`=1 again.
- `rst` pulsed for one cycle after 2 of 4 bytes -> no output word. Then 0x01..0x04 produce exactly {0x01,0x02,0x03,0x04}, keep 4'b1111.
- Random gaps on `in_valid` and random `out_ready` backpressure over 1000 bytes with random `in_last` -> scoreboard requires:
  - byte order preserved;
  - keep and last correct;
  - no loss or duplication;
  - output stable under backpressure.
